fixed_point_abs_acc: RTL
========================

FIXED_POINT_ABS_ACC -- requirements
Module: fixed_point_abs_acc

Interface
REQ-001 SHALL take parameter WIDTH, default 8: width of the input and result words (signed fixed-point).
REQ-002 SHALL take parameter FRAC_BITS, default 3: fractional bits; pass-through only, no rescaling.
REQ-003 SHALL take parameter NUM_SAMPLES, default 4: samples per frame; power of two, 2 to 256.
REQ-004 SHALL have port CLK  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port RSTN  in  1  reset; synchronous, active-low.
REQ-006 SHALL have port START  in  1  one-cycle pulse that opens a new frame.
REQ-007 SHALL have port VALUE_IN  in  WIDTH  signed magnitude sample from the upstream absolute-value stage.
REQ-008 SHALL have port VALID_IN  in  1  qualifies VALUE_IN for one cycle.
REQ-009 SHALL have port BUSY  out  1  high while a frame is collecting samples.
REQ-010 SHALL have port VALUE_OUT  out  WIDTH  frame result (sum or mean, see Configuration).
REQ-011 SHALL have port VALID_OUT  out  1  one-cycle pulse qualifying VALUE_OUT and OVERFLOW.
REQ-012 SHALL have port OVERFLOW  out  1  result was saturated, or an invalid sample was seen in the frame.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-014 IDLE: START SHALL clear the accumulator, sample counter and overflow flag, and move to ACCUM on the next cycle; VALID_IN SHALL be ignored.
REQ-015 ACCUM: BUSY=1; each VALID_IN SHALL add the sample to an internal accumulator of WIDTH+log2(NUM_SAMPLES) bits (no internal wrap) and increment the counter.
REQ-016 ACCUM: the valid sample at count NUM_SAMPLES-1 SHALL be accumulated and the FSM SHALL move to DONE.
REQ-017 START SHALL be ignored in ACCUM and DONE; no frame restart mid-collection.
REQ-018 A sample with its MSB set (negative, i.e. an abs overflow upstream) SHALL be accumulated as the maximum positive value 2^(WIDTH-1)-1 and SHALL set the sticky overflow flag.
REQ-019 DONE SHALL last one cycle: VALUE_OUT, OVERFLOW and VALID_OUT=1 are registered, and the next state is IDLE.
REQ-020 Latency SHALL be exactly 1 cycle from the final sample's VALID_IN edge to VALID_OUT high.
REQ-021 VALUE_OUT and OVERFLOW SHALL hold their last values until the next DONE.
REQ-022 VALID_IN in DONE SHALL be dropped.
REQ-023 START coincident with VALID_IN in IDLE SHALL open the frame without counting that sample.

Reset
REQ-024 While RSTN=0 the FSM SHALL go to IDLE, and the accumulator, counter, BUSY, VALID_OUT, OVERFLOW and VALUE_OUT SHALL clear to 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no VALID_OUT pulse.

Configuration
REQ-026 With macro FIXED_POINT_ABS_ACC_MEAN_EN defined, VALUE_OUT SHALL be the accumulator arithmetically shifted right by log2(NUM_SAMPLES) (truncating mean), which cannot saturate.
REQ-027 Without FIXED_POINT_ABS_ACC_MEAN_EN, VALUE_OUT SHALL be the sum, saturated to 2^(WIDTH-1)-1, and saturation SHALL set OVERFLOW.

Structure
REQ-028 The FSM state enum and the saturation-constant function (max positive for a given WIDTH) SHALL live in the shared fixed-point package.
REQ-029 The block SHALL be flat, with no sub-module; the saturating output stage SHALL be local logic.

Verification (WIDTH=8, FRAC_BITS=3, NUM_SAMPLES=4)
REQ-030 Sum build: START, then samples 0x08, 0x10, 0x04, 0x0C -> VALID_OUT 1 cycle after the last sample, VALUE_OUT=0x28, OVERFLOW=0; with MEAN_EN, VALUE_OUT=0x0A.
REQ-031 Saturation: four samples of 0x7F -> sum build VALUE_OUT=0x7F, OVERFLOW=1; MEAN_EN build VALUE_OUT=0x7F, OVERFLOW=0.
REQ-032 Invalid input: samples 0x80, 0x00, 0x00, 0x00 -> treated as 0x7F; VALUE_OUT=0x7F (sum) or 0x1F (mean), OVERFLOW=1 in both builds.
REQ-033 Gaps and ignores: VALID_IN gapped over 10 cycles, START pulsed mid-frame, VALID_IN before START -> only the 4 in-frame samples are counted; BUSY falls at DONE.
REQ-034 Reset abort: RSTN=0 after 2 samples -> no VALID_OUT; the next full frame of 0x08 x4 gives 0x20 (sum) or 0x08 (mean).

Source files
------------

// File: rtl/fixed_point_abs_acc_pkg.sv
// Shared fixed-point definitions: accumulator FSM state encoding and the
// saturation constant (largest positive value of a signed word).
package fixed_point_abs_acc_pkg;

  localparam int ACC_STATE_W = 2;

  // Explicit encodings keep the debug state output stable across builds.
  typedef enum logic [ACC_STATE_W-1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

  // Largest positive value of a signed word of the given width (width <= 32).
  function automatic logic [31:0] sat_max(input int width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fixed_point_abs_acc.sv
// Frame accumulator for the output of an absolute-value stage.
// A START pulse opens a frame of NUM_SAMPLES valid samples; the frame result
// (saturated sum, or truncating mean) is presented one cycle after the last
// sample together with a one-cycle VALID_OUT pulse.
// Negative samples mean the upstream abs saturated; they are counted as the
// maximum positive value and flag OVERFLOW for the frame.
// Build option: define FIXED_POINT_ABS_ACC_MEAN_EN to output the mean instead
// of the saturated sum.
//
// Handshake: VALID_IN qualifies VALUE_IN for exactly the cycle it is high, and
// there is no backpressure: a sample is taken only in ACCUM, otherwise it is
// dropped. VALID_OUT is a one-cycle pulse; VALUE_OUT/OVERFLOW hold until the
// next frame completes.
module fixed_point_abs_acc
  import fixed_point_abs_acc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FRAC_BITS   = 3,
  parameter int NUM_SAMPLES = 4
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   START,
  input  logic [WIDTH-1:0]       VALUE_IN,
  input  logic                   VALID_IN,
  output logic                   BUSY,
  output logic [WIDTH-1:0]       VALUE_OUT,
  output logic                   VALID_OUT,
  output logic                   OVERFLOW,
  output logic [ACC_STATE_W-1:0] STATE_DBG
);

  localparam int CNT_W = $clog2(NUM_SAMPLES);
  // Wide enough that NUM_SAMPLES maximum-positive samples never wrap.
  localparam int ACC_W = WIDTH + CNT_W;

  localparam logic [WIDTH-1:0] MAX_POS     = WIDTH'(sat_max(WIDTH));
  localparam logic [ACC_W-1:0] MAX_POS_ACC = ACC_W'(sat_max(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(NUM_SAMPLES - 1);

  // Reject unsupported configurations at elaboration time. FRAC_BITS only
  // describes the binary point; values pass through without rescaling.
  if (FRAC_BITS < 0 || FRAC_BITS >= WIDTH || WIDTH > 32 ||
      NUM_SAMPLES < 2 || NUM_SAMPLES > 256 ||
      (NUM_SAMPLES & (NUM_SAMPLES - 1)) != 0) begin : g_param_check
    $error("fixed_point_abs_acc: unsupported WIDTH/FRAC_BITS/NUM_SAMPLES");
  end

  acc_state_t       state;
  acc_state_t       state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             sticky_ov;
  logic             sample_neg;
  logic [WIDTH-1:0] sample_eff;
  logic             take;
  logic             last;
  logic [WIDTH-1:0] result;
  logic             result_ov;

  // Sample conditioning: a set MSB is an upstream abs overflow.
  assign sample_neg = VALUE_IN[WIDTH-1];
  assign sample_eff = sample_neg ? MAX_POS : VALUE_IN;
  assign take       = (state == ACCUM) && VALID_IN;
  assign last       = take && (cnt == LAST_CNT);
  // Sample is non-negative after conditioning, so zero-extension is correct.
  assign acc_sum    = acc + ACC_W'(sample_eff);

`ifdef FIXED_POINT_ABS_ACC_MEAN_EN
  // Mean: the accumulator MSB is always 0, so a logical shift equals the
  // arithmetic one, and the quotient always fits in WIDTH-1 magnitude bits.
  assign result    = WIDTH'(acc_sum >> CNT_W);
  assign result_ov = sticky_ov | sample_neg;
`else
  // Sum: clamp to the largest positive word and report the clamp.
  assign result    = (acc_sum > MAX_POS_ACC) ? MAX_POS : acc_sum[WIDTH-1:0];
  assign result_ov = sticky_ov | sample_neg | (acc_sum > MAX_POS_ACC);
`endif

  assign BUSY      = (state == ACCUM);
  assign STATE_DBG = state;

  // Next-state logic: START only opens a frame from IDLE; DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = ACCUM;
      ACCUM:   if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // Accumulator, sample counter, sticky flag and registered frame result.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      acc       <= '0;
      cnt       <= '0;
      sticky_ov <= 1'b0;
      VALUE_OUT <= '0;
      OVERFLOW  <= 1'b0;
      VALID_OUT <= 1'b0;
    end else begin
      VALID_OUT <= last;
      if (state == IDLE && START) begin
        acc       <= '0;
        cnt       <= '0;
        sticky_ov <= 1'b0;
      end else if (take) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
        if (sample_neg) sticky_ov <= 1'b1;
      end
      if (last) begin
        VALUE_OUT <= result;
        OVERFLOW  <= result_ov;
      end
    end
  end

endmodule
